// File: rtl/pcie_io_req.sv
`default_nettype none
// ============================================================================
// Module   : pcie_io_req
// Brief    : Single-DW PCIe MemRd/MemWr requester over 64-bit AXIS TX/RX,
//            with completion matching by tag and a completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_io_req #(
  parameter int C_DATA_WIDTH   = 64,
  parameter int KEEP_WIDTH     = C_DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0] o_s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]   o_s_axis_tx_tkeep,
  output logic                    o_s_axis_tx_tlast,
  output logic                    o_s_axis_tx_tvalid,
  output logic                    o_tx_src_dsc,
  input  logic [C_DATA_WIDTH-1:0] i_m_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0]   i_m_axis_rx_tkeep,
  input  logic                    i_m_axis_rx_tlast,
  input  logic                    i_m_axis_rx_tvalid,
  output logic                    o_m_axis_rx_tready,
  input  logic [8:0]              i_m_axis_rx_tuser,
  input  logic [15:0]             i_cfg_completer_id,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wren,
  input  logic [31:0]             i_req_addr,
  input  logic [3:0]              i_req_wstrb,
  input  logic [31:0]             i_req_wdata,
  output logic                    o_resp_valid,
  output logic [31:0]             o_resp_rdata,
  output logic                    o_resp_err
);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_tx0  = 3'd1;
  localparam logic [2:0] c_tx1  = 3'd2;
  localparam logic [2:0] c_cpl0 = 3'd3;
  localparam logic [2:0] c_cpl1 = 3'd4;
  localparam logic [2:0] c_drop = 3'd5;
  localparam logic [2:0] c_resp = 3'd6;

  localparam int              c_cnt_w   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic               r_wren;
  logic [29:0]        r_addr;
  logic [3:0]         r_wstrb;
  logic [31:0]        r_wdata;
  logic [7:0]         r_tag;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_rx_sop;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;

  logic               w_ld;
  logic [31:0]        w_ld_rdata;
  logic               w_ld_err;
  logic               w_rx_beat;
  logic               w_waiting;
  logic               w_timeout;
  logic               w_cpl_ok;
  logic               w_tag_ok;
  logic               w_rd_issued;
  logic [31:0]        w_dw0;
  logic [31:0]        w_dw1;
  logic               w_unused;

  assign w_rx_beat   = i_m_axis_rx_tvalid & o_m_axis_rx_tready;
  assign w_waiting   = (r_state == c_cpl0) | (r_state == c_cpl1) | (r_state == c_drop);
  assign w_timeout   = w_waiting & (r_cnt == c_to_last);
  assign w_cpl_ok    = (i_m_axis_rx_tdata[30:24] == 7'b1001010) &&
                       (i_m_axis_rx_tdata[47:45] == 3'b000) && !i_m_axis_rx_tuser[1];
  // The tag was already advanced when the read left TX1, so the outstanding one is r_tag-1.
  assign w_tag_ok    = (i_m_axis_rx_tdata[15:8] == (r_tag - 8'd1));
  assign w_rd_issued = (r_state == c_tx1) & i_s_axis_tx_tready & ~r_wren;

  assign w_dw0 = {1'b0, (r_wren ? 2'b10 : 2'b00), 5'b00000, 1'b0, 3'b000, 4'b0000,
                  1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
  assign w_dw1 = {i_cfg_completer_id, r_tag, 4'b0000, (r_wren ? r_wstrb : 4'hF)};

  assign w_unused = ^{i_m_axis_rx_tkeep, i_m_axis_rx_tuser[8:2], i_m_axis_rx_tuser[0],
                      i_m_axis_rx_tdata[31], i_m_axis_rx_tdata[23:16],
                      i_m_axis_rx_tdata[7:0], i_req_addr[1:0]};

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_state <= c_idle;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ld       = 1'b0;
    w_ld_rdata = 32'h0;
    w_ld_err   = 1'b0;
    case (r_state)
      c_idle: if (i_req_valid) w_next = c_tx0;
      c_tx0:  if (i_s_axis_tx_tready) w_next = c_tx1;
      c_tx1: begin
        if (i_s_axis_tx_tready) begin
          if (r_wren) begin
            w_next = c_resp;
            w_ld   = 1'b1;
          end else begin
            w_next = c_cpl0;
          end
        end
      end
      c_cpl0: begin
        if (w_timeout) begin
          w_next   = c_resp;
          w_ld     = 1'b1;
          w_ld_err = 1'b1;
        end else if (w_rx_beat && r_rx_sop) begin
          if (w_cpl_ok) begin
            w_next = c_cpl1;
          end else if (i_m_axis_rx_tlast) begin
            w_next   = c_resp;
            w_ld     = 1'b1;
            w_ld_err = 1'b1;
          end else begin
            w_next = c_drop;
          end
        end
      end
      c_cpl1: begin
        if (w_timeout) begin
          w_next   = c_resp;
          w_ld     = 1'b1;
          w_ld_err = 1'b1;
        end else if (w_rx_beat) begin
          if (w_tag_ok) begin
            w_next     = c_resp;
            w_ld       = 1'b1;
            w_ld_rdata = i_m_axis_rx_tdata[63:32];
          end else begin
            w_next = i_m_axis_rx_tlast ? c_cpl0 : c_drop;
          end
        end
      end
      c_drop: begin
        if (w_timeout) begin
          w_next   = c_resp;
          w_ld     = 1'b1;
          w_ld_err = 1'b1;
        end else if (w_rx_beat && i_m_axis_rx_tlast) begin
          w_next = c_cpl0;
        end
      end
      c_resp:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    o_req_ready        = (r_state == c_idle);
    o_m_axis_rx_tready = (r_state != c_resp);
    o_resp_valid       = (r_state == c_resp);
    o_resp_rdata       = r_resp_rdata;
    o_resp_err         = r_resp_err;
    o_tx_src_dsc       = 1'b0;
    o_s_axis_tx_tvalid = 1'b0;
    o_s_axis_tx_tlast  = 1'b0;
    o_s_axis_tx_tkeep  = 8'h00;
    o_s_axis_tx_tdata  = 64'h0;
    if (r_state == c_tx0) begin
      o_s_axis_tx_tvalid = 1'b1;
      o_s_axis_tx_tkeep  = 8'hFF;
      o_s_axis_tx_tdata  = {w_dw1, w_dw0};
    end else if (r_state == c_tx1) begin
      o_s_axis_tx_tvalid = 1'b1;
      o_s_axis_tx_tlast  = 1'b1;
      o_s_axis_tx_tkeep  = r_wren ? 8'hFF : 8'h0F;
      o_s_axis_tx_tdata  = {(r_wren ? r_wdata : 32'h0), r_addr, 2'b00};
    end
  end

  // Datapath: request capture, tag, timeout counter, RX framing and response hold.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wren       <= 1'b0;
      r_addr       <= 30'h0;
      r_wstrb      <= 4'h0;
      r_wdata      <= 32'h0;
      r_tag        <= 8'h00;
      r_cnt        <= '0;
      r_rx_sop     <= 1'b1;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      if ((r_state == c_idle) && i_req_valid) begin
        r_wren  <= i_req_wren;
        r_addr  <= i_req_addr[31:2];
        r_wstrb <= i_req_wstrb;
        r_wdata <= i_req_wdata;
      end
      if (w_rd_issued) begin
        r_tag <= r_tag + 8'd1;
        r_cnt <= '0;
      end else if (w_waiting) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rx_beat) r_rx_sop <= i_m_axis_rx_tlast;
      if (w_ld) begin
        r_resp_rdata <= w_ld_rdata;
        r_resp_err   <= w_ld_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcie_io_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_io_req
// Brief    : Scoreboard bench for pcie_io_req with a scripted completer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_io_req;

  localparam int          TO  = 32;
  localparam logic [15:0] CID = 16'hABCD;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        tx_ready = 1'b1;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tvalid, tx_src_dsc;
  logic [63:0] rx_data = 64'h0;
  logic [7:0]  rx_keep = 8'hFF;
  logic        rx_last = 1'b0, rx_valid = 1'b0, rx_ready;
  logic [8:0]  rx_user = 9'h0;
  logic        req_valid = 1'b0, req_ready, req_wren = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  pcie_io_req #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_s_axis_tx_tready(tx_ready), .o_s_axis_tx_tdata(s_tdata), .o_s_axis_tx_tkeep(s_tkeep),
    .o_s_axis_tx_tlast(s_tlast), .o_s_axis_tx_tvalid(s_tvalid), .o_tx_src_dsc(tx_src_dsc),
    .i_m_axis_rx_tdata(rx_data), .i_m_axis_rx_tkeep(rx_keep), .i_m_axis_rx_tlast(rx_last),
    .i_m_axis_rx_tvalid(rx_valid), .o_m_axis_rx_tready(rx_ready), .i_m_axis_rx_tuser(rx_user),
    .i_cfg_completer_id(CID),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wren(req_wren),
    .i_req_addr(req_addr), .i_req_wstrb(req_wstrb), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, last_resp_cyc = 0, resp_cnt = 0, exp_resp_n = 0;
  logic [7:0] exp_tag = 8'h00;

  logic [72:0] exp_tx[$];    // {tlast, tkeep, tdata}
  logic [32:0] exp_resp[$];  // {err, rdata}
  logic [65:0] rxq[$];       // {tlast, err_fwd, tdata}
  int          plan[$];      // beats to return per read

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_rd_tx(input logic [31:0] addr, input logic [7:0] tag);
    exp_tx.push_back({1'b0, 8'hFF, CID, tag, 8'h0F, 32'h0000_0001});
    exp_tx.push_back({1'b1, 8'h0F, 32'h0, addr[31:2], 2'b00});
  endfunction

  function automatic void push_cpld(input logic [7:0] tag, input logic [31:0] data,
                                    input logic [2:0] status, input logic efwd);
    rxq.push_back({1'b0, efwd, 16'h0100, status, 1'b0, 12'd4, 32'h4A00_0001});
    rxq.push_back({1'b1, 1'b0, data, CID, tag, 8'h10});
  endfunction

  function automatic void push_resp(input logic err, input logic [31:0] rdata);
    exp_resp.push_back({err, rdata});
    exp_resp_n++;
  endfunction

  // TX monitor
  always @(negedge clk) begin
    if (s_tvalid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_beat: unexpected beat %h", s_tdata);
      end else begin
        chk("tx_beat", {s_tlast, s_tkeep, s_tdata}, exp_tx.pop_front());
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_resp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL resp: unexpected response err=%b rdata=%h", resp_err, resp_rdata);
      end else begin
        chk("resp", {resp_err, resp_rdata}, exp_resp.pop_front());
      end
      last_resp_cyc = cyc;
      resp_cnt++;
    end
  end

  // Completer: replies right after each read's last TX beat
  initial begin
    logic [65:0] beat;
    int n;
    logic ok;
    forever begin
      @(negedge clk);
      if (nrst && s_tvalid && tx_ready && s_tlast && s_tkeep == 8'h0F) begin
        n = (plan.size() != 0) ? plan.pop_front() : 0;
        @(posedge clk); #1;
        for (int b = 0; b < n; b++) begin
          beat = rxq.pop_front();
          rx_valid = 1'b1; rx_data = beat[63:0]; rx_last = beat[65];
          rx_user = {7'b0, beat[64], 1'b0};
          ok = 1'b0;
          for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); ok = rx_ready;
            @(posedge clk); #1;
          end
          chk("rx_accept", ok, 1'b1);
        end
        rx_valid = 1'b0; rx_last = 1'b0; rx_user = 9'h0;
      end
    end
  end

  task automatic issue(input logic wren, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data);
    logic ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wren = wren; req_addr = addr; req_wstrb = strb; req_wdata = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("req_accept", ok, 1'b1);
  endtask

  task automatic wait_resp();
    logic ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (resp_cnt >= exp_resp_n);
    end
    chk("resp_arrival", ok, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int beats);
    plan.push_back(beats);
    push_rd_tx(addr, exp_tag);
    issue(1'b0, addr, 4'h0, 32'h0);
    exp_tag++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_tx", {s_tvalid, s_tlast, s_tkeep, s_tdata}, 74'h0);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 34'h0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("tx_src_dsc", tx_src_dsc, 1'b0);
    @(posedge clk); #1 nrst = 1'b1;

    // Write, hand-computed beats
    exp_tx.push_back({1'b0, 8'hFF, 64'hABCD_0003_4000_0001});
    exp_tx.push_back({1'b1, 8'hFF, 64'hDEAD_BEEF_0000_1004});
    push_resp(1'b0, 32'h0);
    issue(1'b1, 32'h0000_1004, 4'h3, 32'hDEAD_BEEF);
    wait_resp();
    chk("wr_latency", last_resp_cyc - acc_cyc, 3);

    // Read with immediate CplD, tag 0
    push_cpld(8'h00, 32'h1234_5678, 3'b000, 1'b0);
    push_resp(1'b0, 32'h1234_5678);
    do_read(32'h10, 2);
    wait_resp();
    chk("rd_latency", last_resp_cyc - acc_cyc, 5);
    repeat (3) @(negedge clk);
    chk("resp_hold", {resp_valid, resp_err, resp_rdata}, {2'b00, 32'h1234_5678});

    // Read with TX backpressure; tag 1 in beat0
    tx_ready = 1'b0;
    push_cpld(8'h01, 32'hCAFE_F00D, 3'b000, 1'b0);
    push_resp(1'b0, 32'hCAFE_F00D);
    do_read(32'h20, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("tx0_stable", {s_tvalid, s_tlast, s_tkeep, s_tdata}, {2'b10, 8'hFF, 64'hABCD_010F_0000_0001});
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_resp();

    // Wrong-tag CplD dropped, correct one used
    push_cpld(8'h07, 32'hBAD0_BAD0, 3'b000, 1'b0);
    push_cpld(8'h02, 32'h55AA_1234, 3'b000, 1'b0);
    push_resp(1'b0, 32'h55AA_1234);
    do_read(32'h30, 4);
    wait_resp();

    // No completion -> timeout
    push_resp(1'b1, 32'h0);
    do_read(32'h40, 0);
    wait_resp();
    chk("timeout_latency", last_resp_cyc - acc_cyc, 3 + TO);

    // Single-beat UR completion -> immediate error
    rxq.push_back({1'b1, 1'b0, 16'h0100, 3'b001, 1'b0, 12'd0, 32'h0A00_0000});
    push_resp(1'b1, 32'h0);
    do_read(32'h50, 1);
    wait_resp();

    // Poisoned CplD dropped, then timeout
    push_cpld(8'h05, 32'h0F0F_0F0F, 3'b000, 1'b1);
    push_resp(1'b1, 32'h0);
    do_read(32'h60, 2);
    wait_resp();

    // Reset while waiting for a completion
    do_read(32'h70, 0);
    repeat (4) @(posedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    chk("midrst_resp_rdata", {resp_err, resp_rdata}, 33'h0);
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1'b1);
    repeat (40) @(negedge clk);
    chk("midrst_no_resp", resp_cnt, exp_resp_n);
    exp_tag = 8'h00;

    // 257 back-to-back reads: tag walks 00..FF then wraps to 00
    for (int i = 0; i < 257; i++) begin
      push_cpld(exp_tag, 32'h5A00_0000 | i, 3'b000, 1'b0);
      push_resp(1'b0, 32'h5A00_0000 | i);
      do_read(32'h100 + 32'(i * 4), 2);
      wait_resp();
    end

    repeat (3) @(negedge clk);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);
    chk("rx_queue_empty", rxq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
